// File: rtl/psum_shift_sched.sv
// psum_shift_sched: round-robin scheduler streaming one PE's psums into a shared shift chain
module psum_shift_sched #(
   parameter int NUM_PE = 4,
   parameter int DATA_W = 16,
   parameter int MAX_P = 24,
   localparam int ID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4:0]               p,
   input  logic [NUM_PE-1:0]        pe_req,
   input  logic [NUM_PE*DATA_W-1:0] pe_data,
   output logic [NUM_PE-1:0]        pe_pop,
   output logic                     sr_en,
   output logic [DATA_W-1:0]        sr_d,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_pe,
   output logic [4:0]               out_count,
   output logic                     busy
);
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
   state_t state, nxt;
   logic [4:0] cnt, p_eff, p_clamp;
   logic [ID_W-1:0] rr_ptr, grant_id, gnt;
   logic [2*NUM_PE-1:0] rot;
   logic last;
   assign last = cnt == p_eff - 5'd1;
   // clamp the requested depth and find the first requester at or after rr_ptr
   always_comb begin
      p_clamp = (p == 5'd0) ? 5'd1 : (p > 5'(MAX_P)) ? 5'(MAX_P) : p;
      rot = {pe_req, pe_req} >> rr_ptr;
      gnt = rr_ptr;
      for (int k = NUM_PE - 1; k >= 0; k--)
         if (rot[k]) gnt = ID_W'((int'(rr_ptr) + k) % NUM_PE);
   end
   // next state and outputs, all forced low while reset is asserted
   always_comb begin
      nxt = state;
      sr_en = 1'b0;
      pe_pop = '0;
      sr_d = '0;
      out_valid = 1'b0;
      out_pe = '0;
      out_count = '0;
      busy = 1'b0;
      if (!reset) begin
         busy = state != IDLE;
         if (state == IDLE && |pe_req) nxt = LOAD;
         if (state == LOAD) begin
            sr_en = 1'b1;
            pe_pop = NUM_PE'(1) << grant_id;
            sr_d = pe_data[grant_id*DATA_W +: DATA_W];
            nxt = last ? HOLD : LOAD;
         end
         if (state == HOLD) begin
            out_valid = 1'b1;
            out_pe = grant_id;
            out_count = p_eff;
            nxt = out_ready ? IDLE : HOLD;
         end
      end
   end
   // state register plus grant, count and round-robin pointer bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= 5'd0;
         rr_ptr <= '0;
         grant_id <= '0;
         p_eff <= 5'd1;
      end else begin
         state <= nxt;
         if (state == IDLE && |pe_req) begin
            grant_id <= gnt;
            p_eff <= p_clamp;
            cnt <= 5'd0;
         end
         if (state == LOAD) cnt <= last ? 5'd0 : cnt + 5'd1;
         if (state == HOLD && out_ready) rr_ptr <= (grant_id == ID_W'(NUM_PE - 1)) ? '0 : grant_id + 1'b1;
      end
   end
endmodule

// File: tb/tb_psum_shift_sched.sv
// tb_psum_shift_sched: directed table and sequence checks for the psum shift scheduler
module tb_psum_shift_sched;
   localparam int NP = 4;
   localparam int DW = 16;
   typedef struct {
      logic rst; logic [4:0] p; logic [3:0] req; logic rdy;
      logic en; logic [3:0] pop; logic [15:0] d; logic ov; logic [1:0] ope; logic [4:0] oc; logic bz;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] p;
   logic [NP-1:0] pe_req;
   logic [NP*DW-1:0] pe_data;
   logic [NP-1:0] pe_pop;
   logic sr_en;
   logic [DW-1:0] sr_d;
   logic out_valid, out_ready;
   logic [1:0] out_pe;
   logic [4:0] out_count;
   logic busy;
   int passed = 0;
   int total = 0;
   logic [7:0] idx [NP];
   int exp_idx [NP];
   vec_t tv [10];

   psum_shift_sched dut (
      .clk(clk), .reset(reset), .p(p), .pe_req(pe_req), .pe_data(pe_data), .pe_pop(pe_pop),
      .sr_en(sr_en), .sr_d(sr_d), .out_valid(out_valid), .out_ready(out_ready),
      .out_pe(out_pe), .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;
   // each PE presents a stream of words and advances when popped
   always_ff @(posedge clk)
      for (int i = 0; i < NP; i++) idx[i] <= reset ? 8'd0 : idx[i] + 8'(pe_pop[i]);
   // PE i word k = 0x0A + i*0x100 + k
   always_comb
      for (int i = 0; i < NP; i++) pe_data[i*DW +: DW] = 16'h0A + 16'(i * 256) + 16'(idx[i]);

   function automatic logic [15:0] word(input int pe, input int k);
      return 16'h0A + 16'(pe * 256 + k);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_out(input string t, input logic en, input logic [3:0] pop, input logic [15:0] d,
                          input logic ov, input logic [1:0] ope, input logic [4:0] oc, input logic bz);
      chk({t, ".sr_en"}, 32'(sr_en), 32'(en));
      chk({t, ".pe_pop"}, 32'(pe_pop), 32'(pop));
      chk({t, ".sr_d"}, 32'(sr_d), 32'(d));
      chk({t, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({t, ".out_pe"}, 32'(out_pe), 32'(ope));
      chk({t, ".out_count"}, 32'(out_count), 32'(oc));
      chk({t, ".busy"}, 32'(busy), 32'(bz));
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_model;
      for (int i = 0; i < NP; i++) exp_idx[i] = 0;
   endtask

   task automatic do_reset;
      reset = 1'b1; pe_req = '0; out_ready = 1'b0; p = 5'd1;
      #1 chk_out("rst_in", 0, 0, 0, 0, 0, 0, 0);
      step;
      reset = 1'b0;
      clear_model();
      #1 chk_out("rst_after", 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic txn(input string nm, input logic [3:0] req, input logic [4:0] pv, input logic [4:0] pmid,
                      input logic [3:0] hreq, input int pe, input int n_exp, input int hold);
      int n;
      pe_req = req; p = pv; out_ready = 1'b0;
      #1;
      chk({nm, ".idle_busy"}, 32'(busy), 0);
      chk({nm, ".idle_en"}, 32'(sr_en), 0);
      step;
      pe_req = hreq; p = pmid;
      #1;
      n = 0;
      while (sr_en && n < 40) begin
         chk({nm, ".pop"}, 32'(pe_pop), 32'(1 << pe));
         chk({nm, ".sr_d"}, 32'(sr_d), 32'(word(pe, exp_idx[pe])));
         exp_idx[pe]++;
         n++;
         step;
         #1;
      end
      chk({nm, ".load_len"}, 32'(n), 32'(n_exp));
      chk({nm, ".out_valid"}, 32'(out_valid), 1);
      chk({nm, ".out_pe"}, 32'(out_pe), 32'(pe));
      chk({nm, ".out_count"}, 32'(out_count), 32'(n_exp));
      repeat (hold) begin
         step;
         #1;
         chk({nm, ".hold_valid"}, 32'(out_valid), 1);
         chk({nm, ".hold_pop"}, 32'(pe_pop), 0);
         chk({nm, ".hold_en"}, 32'(sr_en), 0);
      end
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
   endtask

   initial begin
      tv[0] = '{1, 3, 4'b0000, 0, 0, 4'b0000, 16'h00, 0, 0, 0, 0};
      tv[1] = '{1, 3, 4'b0000, 0, 0, 4'b0000, 16'h00, 0, 0, 0, 0};
      tv[2] = '{0, 3, 4'b0000, 0, 0, 4'b0000, 16'h00, 0, 0, 0, 0};
      tv[3] = '{0, 3, 4'b0001, 1, 0, 4'b0000, 16'h00, 0, 0, 0, 0};
      tv[4] = '{0, 3, 4'b0000, 1, 1, 4'b0001, 16'h0A, 0, 0, 0, 1};
      tv[5] = '{0, 3, 4'b0000, 1, 1, 4'b0001, 16'h0B, 0, 0, 0, 1};
      tv[6] = '{0, 3, 4'b0000, 1, 1, 4'b0001, 16'h0C, 0, 0, 0, 1};
      tv[7] = '{0, 3, 4'b0000, 0, 0, 4'b0000, 16'h00, 1, 0, 3, 1};
      tv[8] = '{0, 3, 4'b0000, 1, 0, 4'b0000, 16'h00, 1, 0, 3, 1};
      tv[9] = '{0, 3, 4'b0000, 0, 0, 4'b0000, 16'h00, 0, 0, 0, 0};
      for (int i = 0; i < 10; i++) begin
         reset = tv[i].rst; p = tv[i].p; pe_req = tv[i].req; out_ready = tv[i].rdy;
         #1 chk_out($sformatf("vec%0d", i), tv[i].en, tv[i].pop, tv[i].d, tv[i].ov, tv[i].ope, tv[i].oc, tv[i].bz);
         step;
      end
      do_reset();
      for (int g = 0; g < 5; g++) txn($sformatf("rr%0d", g), 4'b1111, 5'd2, 5'd2, 4'b1111, g % 4, 2, 0);
      txn("p0", 4'b0001, 5'd0, 5'd0, 4'b0001, 0, 1, 0);
      txn("p31", 4'b0001, 5'd31, 5'd31, 4'b0001, 0, 24, 0);
      txn("pchg", 4'b0010, 5'd4, 5'd7, 4'b0010, 1, 4, 0);
      txn("hold", 4'b1000, 5'd2, 5'd2, 4'b0110, 3, 2, 10);
      txn("after_hold", 4'b0110, 5'd3, 5'd3, 4'b0110, 1, 3, 0);
      pe_req = 4'b0001; p = 5'd5; out_ready = 1'b0;
      #1 step;
      pe_req = 4'b0000;
      #1 chk("mid.load1_en", 32'(sr_en), 1);
      chk("mid.load1_d", 32'(sr_d), 32'(word(0, exp_idx[0])));
      step;
      reset = 1'b1;
      #1 chk_out("mid_rst_in", 0, 0, 0, 0, 0, 0, 0);
      step;
      reset = 1'b0;
      clear_model();
      #1 chk_out("mid_rst_after", 0, 0, 0, 0, 0, 0, 0);
      step;
      #1 chk("mid.no_pulse_en", 32'(sr_en), 0);
      chk("mid.no_pulse_busy", 32'(busy), 0);
      txn("fresh", 4'b0100, 5'd5, 5'd5, 4'b0100, 2, 5, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
